router_output_arbiter: RTL and testbench
========================================

Name: router_output_arbiter

Overview:
Output-port stage of the NoC router. It sits directly downstream of the per-direction input channel buffers and consumes their request/packet pairs. It picks one requester per cycle using round-robin order, returns a one-hot grant, and rewrites the hop field. The chosen packet is latched into a single 64-bit output register, which is drained to the link (or PE) through a valid/ready handshake.

Parameters:
N, 4, number of input channel buffers competing for this output port (2..8)
DECR_HOP, 1, 1 = decrement hop field [55:48] on forward (link port); 0 = pass unchanged (PE port)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  N  req[i] = input buffer i holds a packet destined for this port
pkt_in  input  64*N  packet of buffer i at bits [64*i+63:64*i]
grant  output  N  one-hot; grant[i]=1 in the cycle buffer i's packet is captured (combinational)
out_pkt  output  64  registered outgoing packet
out_valid  output  1  out_pkt holds a valid packet
out_ready  input  1  downstream accepts out_pkt when out_valid & out_ready
fwd_count  output  16  number of packets accepted into the output register, wraps at 16'hFFFF->0

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - out_pkt=0, out_valid=0, fwd_count=0.
  - Round-robin pointer ptr=0.
  - grant is forced to 0 during the reset cycle.
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- Drain: drain = out_valid & out_ready.
- Accept condition: accept = (|req) & (~out_valid | drain).
  - Capture is allowed in the same cycle as a drain, giving zero-bubble back-to-back forwarding.
- Arbitration:
  - Search req starting at index ptr, ascending, wrapping N-1 -> 0.
  - The first set bit w is the winner.
  - grant = accept ? onehot(w) : 0.
  - grant is never multi-hot, and never asserted when req=0.
- On the accepting edge:
  - out_pkt <= modified pkt_in[w]; out_valid <= 1.
  - ptr <= (w+1) mod N.
  - fwd_count <= fwd_count+1.
- On a drain edge with no accept: out_valid <= 0; out_pkt holds its old value.
- With no drain and no accept: all state holds.
  - ptr changes only on accept.
  - A FULL register with out_ready=0 stalls indefinitely, with grant=0.
- Hop rewrite (DECR_HOP=1):
  - out_pkt[55:48] = hop-1 when hop != 0.
  - hop==0 saturates: passed as 0, no underflow.
  - All other bits are copied unchanged.
  - DECR_HOP=0 copies all 64 bits unchanged.
- Latency: req to out_valid is 1 cycle (register in the accept cycle, visible next cycle).
- Grant is the capture acknowledge. The input buffer must clear or replace its packet on the edge where grant[i]=1. A req held after grant is treated as a new packet.
- An all-zero packet with req=1 is still forwarded; the arbiter does not inspect the payload for validity.
- Reset mid-transfer: a FULL register is discarded (out_valid->0) and no grant is issued in the reset cycle.

Test Plan:
- Reset while FULL with out_ready=0 -> next cycle out_valid=0, out_pkt=0, fwd_count=0, grant=0. The first later accept with req=4'b1111 grants buffer 0.
- Single requester: req=4'b0100, pkt_in[2]=64'h00_05_0000_0000_1234, out_ready=1 -> grant=4'b0100 in that cycle. Next cycle out_valid=1 and out_pkt=64'h00_04_0000_0000_1234.
- Round-robin fairness: req held at 4'b1111, out_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 with one packet per cycle. fwd_count=8 at the end.
- Backpressure: out_ready=0 after the first capture with req=4'b0011 -> grant=0 and out_pkt is stable for 5 cycles. Raising out_ready -> drain and capture of buffer 1 on the same edge, so out_valid stays 1.
- Hop boundaries with DECR_HOP=1:
  - hop 8'h00 -> out hop 8'h00 (saturated).
  - hop 8'h01 -> out hop 8'h00.
  - hop 8'hFF -> out hop 8'hFE.
  - Bits outside [55:48] are identical in all three cases.
- Counter wrap: preload fwd_count to 16'hFFFF via 65535 forwards (or force), then one more accept -> fwd_count=16'h0000.

Source files
------------

// File: rtl/router_output_arbiter.sv
// NoC router output-port stage: round-robin pick among N input buffers,
// hop-field rewrite, and a single-entry 64-bit output register drained by valid/ready.
module router_output_arbiter #(
   parameter int N        = 4,
   parameter bit DECR_HOP = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [64*N-1:0]   pkt_in,
   output logic [N-1:0]      grant,
   output logic [63:0]       out_pkt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       fwd_count
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t          r_state;
   logic [63:0]     r_pkt;
   logic [PW-1:0]   r_ptr;
   logic [15:0]     r_cnt;

   logic            w_drain;
   logic            w_accept;
   logic            w_found;
   logic [PW-1:0]   w_win;
   logic [PW-1:0]   w_cand;
   logic [63:0]     w_sel;
   logic [63:0]     w_mod;
   logic [7:0]      w_hop;
   logic [N-1:0]    w_grant;

   // Handshake: a packet leaves on any edge where out_valid & out_ready; a new
   // packet may be captured on that same edge, so a busy link sees no bubble.
   assign w_drain  = (r_state == S_FULL) && out_ready;
   assign w_accept = (|req) && ((r_state == S_EMPTY) || w_drain);

   // First requester at or after the pointer, wrapping past N-1.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = PW'((int'(r_ptr) + k) % N);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (w_win == PW'(i)) w_sel = pkt_in[64*i +: 64];
      end
   end

   // Hop count saturates at zero rather than wrapping.
   always_comb begin
      w_hop = w_sel[55:48];
      if (DECR_HOP && (w_hop != 8'd0)) w_hop = w_hop - 8'd1;
      w_mod = {w_sel[63:56], w_hop, w_sel[47:0]};
   end

   assign w_grant = (w_accept && !reset) ? (N'(1) << w_win) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_pkt   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_state <= S_FULL;
         r_pkt   <= w_mod;
         r_ptr   <= (w_win == PW'(N-1)) ? '0 : w_win + PW'(1);
         r_cnt   <= r_cnt + 16'd1;
      end else if (w_drain) begin
         r_state <= S_EMPTY;
      end
   end

   assign grant     = w_grant;
   assign out_pkt   = r_pkt;
   assign out_valid = (r_state == S_FULL);
   assign fwd_count = r_cnt;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter (N=4, DECR_HOP=1): directed steps then random
// traffic, compared against a cycle-level reference model and a drain queue.
module tb_router_output_arbiter;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic [64*N-1:0]   pkt_in;
   logic [N-1:0]      grant;
   logic [63:0]       out_pkt;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       fwd_count;

   router_output_arbiter #(.N(N), .DECR_HOP(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .pkt_in    (pkt_in),
      .grant     (grant),
      .out_pkt   (out_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fwd_count (fwd_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [63:0] pkts [N];
   logic        m_valid;
   logic [63:0] m_pkt;
   int          m_ptr;
   logic [15:0] m_cnt;
   logic [63:0] exp_q [$];
   logic [N-1:0] g_seen;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Forwarded packet: one hop consumed unless the hop field is already zero.
   function automatic logic [63:0] fwd_model(input logic [63:0] p);
      if (p[55:48] != 8'd0) return p - 64'h0001_0000_0000_0000;
      return p;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic step(input logic [N-1:0] r, input logic rdy, input logic rst);
      logic [N-1:0] exp_g;
      logic         drn;
      logic         acc;
      int           w;
      req       = r;
      out_ready = rdy;
      reset     = rst;
      for (int i = 0; i < N; i++) pkt_in[64*i +: 64] = pkts[i];
      #1;
      drn   = m_valid && rdy;
      acc   = !rst && (r != '0) && (!m_valid || drn);
      w     = pick(r, m_ptr);
      exp_g = acc ? (N'(1) << w) : '0;
      g_seen = grant;
      check64("grant", 64'(grant), 64'(exp_g));
      if (!rst && drn) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL drain_unexpected observed=%h expected=none", out_pkt);
         end else begin
            check64("drain_pkt", out_pkt, exp_q.pop_front());
         end
      end
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_pkt   = '0;
         m_ptr   = 0;
         m_cnt   = '0;
         exp_q.delete();
      end else if (acc) begin
         m_pkt   = fwd_model(pkts[w]);
         m_valid = 1'b1;
         m_ptr   = (w + 1) % N;
         m_cnt   = m_cnt + 16'd1;
         exp_q.push_back(m_pkt);
      end else if (drn) begin
         m_valid = 1'b0;
      end
      #1;
      check64("out_valid", 64'(out_valid), 64'(m_valid));
      check64("out_pkt", out_pkt, m_pkt);
      check64("fwd_count", 64'(fwd_count), 64'(m_cnt));
   endtask

   task automatic rand_pkts();
      for (int i = 0; i < N; i++) pkts[i] = {$urandom, $urandom};
   endtask

   initial begin
      logic [63:0] base;
      m_valid = 1'b0; m_pkt = '0; m_ptr = 0; m_cnt = '0;
      req = '0; out_ready = 1'b0; reset = 1'b1; pkt_in = '0;
      rand_pkts();

      // Reset while FULL and stalled.
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b1);
      check64("rst_valid", 64'(out_valid), 64'd0);
      check64("rst_pkt", out_pkt, 64'd0);
      check64("rst_cnt", 64'(fwd_count), 64'd0);
      step(4'b1111, 1'b1, 1'b0);
      check64("rst_first_grant", 64'(g_seen), 64'b0001);

      // Single requester with hop 5.
      step(4'b0000, 1'b0, 1'b1);
      pkts[2] = 64'h0005_0000_0000_1234;
      step(4'b0100, 1'b1, 1'b0);
      check64("single_grant", 64'(g_seen), 64'b0100);
      check64("single_pkt", out_pkt, 64'h0004_0000_0000_1234);

      // Round-robin across all four buffers.
      step(4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         rand_pkts();
         step(4'b1111, 1'b1, 1'b0);
         check64("rr_order", 64'(g_seen), 64'(1) << (i % 4));
      end
      check64("rr_count", 64'(fwd_count), 64'd8);

      // Backpressure then zero-bubble drain+capture.
      step(4'b0000, 1'b0, 1'b1);
      rand_pkts();
      step(4'b0011, 1'b1, 1'b0);
      base = out_pkt;
      for (int i = 0; i < 5; i++) begin
         step(4'b0011, 1'b0, 1'b0);
         check64("bp_grant", 64'(g_seen), 64'd0);
         check64("bp_stable", out_pkt, base);
      end
      step(4'b0011, 1'b1, 1'b0);
      check64("bp_resume_grant", 64'(g_seen), 64'b0010);
      check64("bp_resume_valid", 64'(out_valid), 64'd1);

      // Hop boundaries.
      base = {$urandom, $urandom};
      pkts[0] = {base[63:56], 8'h00, base[47:0]};
      step(4'b0001, 1'b1, 1'b0);
      check64("hop00", out_pkt, {base[63:56], 8'h00, base[47:0]});
      pkts[1] = {base[63:56], 8'h01, base[47:0]};
      step(4'b0010, 1'b1, 1'b0);
      check64("hop01", out_pkt, {base[63:56], 8'h00, base[47:0]});
      pkts[2] = {base[63:56], 8'hFF, base[47:0]};
      step(4'b0100, 1'b1, 1'b0);
      check64("hopFF", out_pkt, {base[63:56], 8'hFE, base[47:0]});

      // Counter wrap: 65535 back-to-back forwards, then one more.
      step(4'b0000, 1'b0, 1'b1);
      rand_pkts();
      req = 4'b0001; out_ready = 1'b1; reset = 1'b0;
      for (int i = 0; i < N; i++) pkt_in[64*i +: 64] = pkts[i];
      repeat (65535) @(posedge clk);
      #1;
      m_cnt = 16'hFFFF; m_valid = 1'b1; m_pkt = fwd_model(pkts[0]); m_ptr = 1;
      exp_q.delete();
      exp_q.push_back(m_pkt);
      check64("wrap_pre", 64'(fwd_count), 64'hFFFF);
      step(4'b0001, 1'b1, 1'b0);
      check64("wrap_post", 64'(fwd_count), 64'h0000);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rand_pkts();
         if ($urandom_range(0, 7) == 0) pkts[$urandom_range(0, N-1)][55:48] = 8'($urandom_range(0, 1));
         step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
